// File: rtl/pipeline_pkg.sv
// Shared types for the multiply/divide unit.
// Contents: muldiv_op_e (RV32M funct3 encoding), muldiv_state_e (FSM states),
//           MULDIV_OP_W (width of the op field).
package pipeline_pkg;

  localparam int unsigned MULDIV_OP_W = 3;

  typedef enum logic [MULDIV_OP_W-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider, one quotient bit per step, plus the shared step counter.
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   load            - capture dividend/divisor magnitudes and clear the counter
//   step            - perform one shift-subtract step and advance the counter
//   dividend        - dividend magnitude (XLEN)
//   divisor         - divisor magnitude (XLEN)
//   quo_next_c      - quotient as it will be after this cycle (combinational)
//   rem_next_c      - remainder as it will be after this cycle (combinational)
//   last_c          - current step is the final one (combinational)
module muldiv_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next_c,
  output logic [XLEN-1:0] rem_next_c,
  output logic            last_c
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  divisor_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  quo_n;
  logic [XLEN-1:0]  rem_n;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // keep the subtraction only if it did not go negative.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, divisor_q};
    if (!diff[XLEN]) begin
      rem_n = diff[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign quo_next_c = step ? quo_n : quo_q;
  assign rem_next_c = step ? rem_n : rem_q;
  assign last_c     = (cnt_q == CNT_W'(XLEN - 1));

  // Quotient register doubles as the dividend shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (load) begin
      quo_q     <= dividend;
      rem_q     <= '0;
      divisor_q <= divisor;
      cnt_q     <= '0;
    end else if (step) begin
      quo_q     <= quo_n;
      rem_q     <= rem_n;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with IDLE/BUSY/DONE control FSM.
// XLEN is 32 or 64. Macro MULDIV_FAST_MUL_EN selects a single-cycle
// combinational multiplier; division is iterative in both builds.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   start      - request a new operation (sampled in IDLE only)
//   flush      - abort whatever is in flight, no done pulse
//   op         - funct3 operation code
//   a, b       - rs1 / rs2 operands
//   rd_in      - destination tag of the request
//   rd_out     - destination tag of the last completed operation
//   busy       - state is not IDLE
//   done       - one-cycle completion strobe
//   result     - result of the last completed operation
module muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   flush,
  input  logic [MULDIV_OP_W-1:0] op,
  input  logic [XLEN-1:0]        a,
  input  logic [XLEN-1:0]        b,
  input  logic [4:0]             rd_in,
  output logic [4:0]             rd_out,
  output logic                   busy,
  output logic                   done,
  output logic [XLEN-1:0]        result
);

  localparam int unsigned XLEN2 = 2 * XLEN;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_in, op_q, op_s;
  logic [4:0]      rd_q;
  logic            res_neg_q;
  logic [XLEN2-1:0] prod_q, prod_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN:0]   mul_sum;

  logic            a_signed, b_signed, a_neg, b_neg, res_neg_in;
  logic [XLEN-1:0] ma, mb;
  logic            div_zero, div_ovf, fast_in, skip_in, accept, idle, neg_s;
  logic [XLEN2-1:0] prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_c;
  logic [XLEN-1:0] quo_next_c, rem_next_c;
  logic            last_c;

  assign op_in = muldiv_op_e'(op);

  // Operand decode: signedness, magnitudes and the sign of the final result.
  always_comb begin
    a_signed   = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                 (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed   = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg      = a_signed && a[XLEN-1];
    b_neg      = b_signed && b[XLEN-1];
    ma         = a_neg ? -a : a;
    mb         = b_neg ? -b : b;
    // Remainder takes the dividend's sign; products and quotients the xor.
    res_neg_in = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero   = op[2] && (b == '0);
    div_ovf    = (op_in == OP_DIV || op_in == OP_REM) && (a == MOST_NEG) && (b == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  assign fast_in = ~op[2];
`else
  assign fast_in = 1'b0;
`endif

  assign skip_in = div_zero || div_ovf || fast_in;
  assign accept  = (state_q == ST_IDLE) && start && !flush;
  assign idle    = (state_q == ST_IDLE);

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = skip_in ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Shift-add multiplier: product register holds {accumulator, multiplier}.
  always_comb begin
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mul_sum = '0;
    if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
      if (fast_in) begin
        prod_d = XLEN2'(ma) * XLEN2'(mb);
      end else begin
        prod_d  = {XLEN'(0), mb};
        mcand_d = ma;
      end
`else
      prod_d  = {XLEN'(0), mb};
      mcand_d = ma;
`endif
    end else if (state_q == ST_BUSY) begin
      mul_sum = {1'b0, prod_q[XLEN2-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      prod_d  = {mul_sum, prod_q[XLEN-1:1]};
    end
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div_core (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .step       (state_q == ST_BUSY),
    .dividend   (ma),
    .divisor    (mb),
    .quo_next_c (quo_next_c),
    .rem_next_c (rem_next_c),
    .last_c     (last_c)
  );

  // Sign fix-up and result select. Uses next-cycle datapath values so the
  // registered result is valid in the DONE cycle; IDLE->DONE shortcuts use
  // the live request.
  always_comb begin
    op_s     = idle ? op_in : op_q;
    neg_s    = idle ? res_neg_in : res_neg_q;
    prod_fix = neg_s ? -prod_d : prod_d;
    quo_fix  = neg_s ? -quo_next_c : quo_next_c;
    rem_fix  = neg_s ? -rem_next_c : rem_next_c;
    final_c  = '0;
    if (!op_s[2]) begin
      final_c = (op_s == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[XLEN2-1:XLEN];
    end else if (idle && div_zero) begin
      final_c = op_s[1] ? a : '1;
    end else if (idle && div_ovf) begin
      final_c = op_s[1] ? '0 : a;
    end else begin
      final_c = op_s[1] ? rem_fix : quo_fix;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      op_q      <= OP_MUL;
      rd_q      <= '0;
      res_neg_q <= 1'b0;
      prod_q    <= '0;
      mcand_q   <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      if (accept) begin
        op_q      <= op_in;
        rd_q      <= rd_in;
        res_neg_q <= res_neg_in;
      end
      if (state_d == ST_DONE) begin
        result <= final_c;
        rd_out <= idle ? rd_in : rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit instance exercised with directed
// and random operations, and a 64-bit instance for wide division.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic        start = 0, flush = 0;
  logic [2:0]  op = 0;
  logic [31:0] a = 0, b = 0;
  logic [4:0]  rd_in = 0, rd_out;
  logic        busy, done;
  logic [31:0] result;

  logic        start64 = 0, flush64 = 0;
  logic [2:0]  op64 = 0;
  logic [63:0] a64 = 0, b64 = 0;
  logic [4:0]  rd_in64 = 0, rd_out64;
  logic        busy64, done64;
  logic [63:0] result64;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .rd_in(rd_in), .rd_out(rd_out), .busy(busy),
    .done(done), .result(result)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .flush(flush64), .op(op64),
    .a(a64), .b(b64), .rd_in(rd_in64), .rd_out(rd_out64), .busy(busy64),
    .done(done64), .result(result64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy, sp;
    logic [63:0] ux, uy, up;
    logic        ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    ux  = {32'h0, x};
    uy  = {32'h0, y};
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin sp = sx * sy; up = sp; return up[31:0]; end
      3'd1: begin sp = sx * sy; up = sp; return up[63:32]; end
      3'd2: begin sp = sx * longint'(uy); up = sp; return up[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        sp = sx / sy; up = sp; return up[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'h0;
        sp = sx % sy; up = sp; return up[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2]) return FAST ? 1 : 33;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  // Issue one 32-bit request, optionally keeping start high while busy.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input bit hold);
    exp_t e;
    int   n, bc, lat;
    @(negedge clk);
    start = 1; op = o; a = x; b = y; rd_in = r;
    lat   = latency(o, x, y);
    e.res = 64'(model(o, x, y));
    e.rd  = r;
    e.cyc = cyc + lat;
    q32.push_back(e);
    @(negedge clk);
    start = hold;
    n = 0; bc = 0;
    while (busy && n < 200) begin
      bc++;
      if (done) start = 0;
      @(negedge clk);
      n++;
    end
    start = 0;
    chk("busy_cycles", 64'(bc), 64'(lat));
  endtask

  task automatic issue64(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] r);
    exp_t e;
    int   n;
    @(negedge clk);
    start64 = 1; op64 = o; a64 = x; b64 = y; rd_in64 = r;
    if (y == 0) e.res = (o == 3'd7) ? x : 64'hFFFF_FFFF_FFFF_FFFF;
    else        e.res = (o == 3'd5) ? x / y : x % y;
    e.rd  = r;
    e.cyc = cyc + ((y == 0) ? 1 : 65);
    q64.push_back(e);
    @(negedge clk);
    start64 = 0;
    n = 0;
    while (busy64 && n < 300) begin @(negedge clk); n++; end
    chk("busy64_bounded", 64'(n < 300), 64'(1));
  endtask

  // Monitors: every done pulse pops the oldest expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (q32.size() == 0) begin
        total++; bad++;
        $display("FAIL done32_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("result32", 64'(result), e.res);
        chk("rd_out32", 64'(rd_out), 64'(e.rd));
        chk("done32_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && done64) begin
      if (q64.size() == 0) begin
        total++; bad++;
        $display("FAIL done64_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q64.pop_front();
        chk("result64", result64, e.res);
        chk("rd_out64", 64'(rd_out64), 64'(e.rd));
        chk("done64_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int c0;
    logic [2:0] ops[11] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd5, 3'd4, 3'd6, 3'd4, 3'd6, 3'd2};
    logic [31:0] as[11] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'sd7, -32'sd7, 32'd100,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs[11] = '{-32'sd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_rd_out", 64'(rd_out), 0);
    chk("rst_busy64", 64'(busy64), 0);
    chk("rst_result64", result64, 0);
    reset = 1;

    for (int i = 0; i < 11; i++) issue(ops[i], as[i], bs[i], 5'(i + 1), 1'b0);

    // start held high through BUSY and DONE must give a single completion
    issue(3'd5, 32'd100, 32'd7, 5'd20, 1'b1);

    // flush in BUSY: no completion; the following request keeps its own tag
    @(negedge clk);
    start = 1; op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd9; c0 = cyc;
    @(negedge clk);
    start = 0;
    while (cyc < c0 + 10) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", 64'(busy), 0);
    issue(3'd5, 32'd100, 32'd7, 5'd10, 1'b0);

    // flush wins over start in IDLE
    @(negedge clk);
    start = 1; flush = 1; op = 3'd5; a = 32'd9; b = 32'd2; rd_in = 5'd3;
    @(negedge clk);
    start = 0; flush = 0;
    chk("flush_over_start", 64'(busy), 0);

    for (int i = 0; i < 40; i++)
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)), 1'b0);

    // reset in the middle of a divide
    @(negedge clk);
    start = 1; op = 3'd4; a = -32'sd7; b = 32'd2; rd_in = 5'd7; c0 = cyc;
    @(negedge clk);
    start = 0;
    while (cyc < c0 + 5) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 1);
    #2 reset = 0;
    #1;
    chk("mid_reset_busy", 64'(busy), 0);
    chk("mid_reset_result", 64'(result), 0);
    chk("mid_reset_rd_out", 64'(rd_out), 0);
    @(negedge clk);
    reset = 1;
    repeat (40) @(negedge clk);
    chk("post_reset_busy", 64'(busy), 0);

    issue64(3'd5, 64'h8000_0000_0000_0000, 64'd3, 5'd11);
    issue64(3'd7, 64'h8000_0000_0000_0000, 64'd3, 5'd12);
    issue64(3'd5, 64'd123, 64'd0, 5'd13);
    for (int i = 0; i < 4; i++)
      issue64(($urandom_range(0, 1) != 0) ? 3'd5 : 3'd7, {$urandom(), $urandom()},
              {32'h0, $urandom()}, 5'(i + 14));

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(q32.size() + q64.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
